// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   Write-only SPI (mode 0) target that loads the PWM peripheral's configuration
//   registers. SCLK, COPI and nCS arrive asynchronously from pins. Each one is
//   synchronised into clk and then decoded as 16-bit frames sent MSB first:
//   {R/W, addr[6:0], data[7:0]}.
//
//   Parameters
//     SYNC_STAGES  flops per input synchroniser (>= 2); sets commit latency
//     MAX_ADDR     highest writable address; larger addresses are discarded
//
//   Ports
//     clk              system clock
//     rst_n            asynchronous active-low reset (synchronous release upstream)
//     sclk             SPI clock, idle low, data taken on its rising edge
//     copi             SPI serial data in
//     ncs              SPI chip select, active low
//     en_reg_out_7_0   reg 0x00: output enable, outputs 7..0
//     en_reg_out_15_8  reg 0x01: output enable, outputs 15..8
//     en_reg_pwm_7_0   reg 0x02: PWM select, outputs 7..0
//     en_reg_pwm_15_8  reg 0x03: PWM select, outputs 15..8
//     pwm_duty_cycle   reg 0x04: duty cycle (0x00 = 0 %, 0xFF = 100 %)
//     wr_strobe        one-clk pulse in the cycle a register is written
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [6:0] MAX_ADDR_C  = 7'(MAX_ADDR);
    localparam logic [4:0] FRAME_BITS  = 5'd16;
    localparam logic [4:0] CNT_SAT     = 5'd17;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Synchroniser chains; the last stage is the only version decode ever uses.
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] copi_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic                   sclk_hist_r;
    logic                   ncs_hist_r;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise_s;
    logic ncs_rise_s;
    logic ncs_fall_s;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] shift_r;
    logic [15:0] shift_next_s;
    logic [4:0]  bit_cnt_r;
    logic [4:0]  bit_cnt_next_s;
    logic        wr_en_s;

    logic [7:0] reg0_r;
    logic [7:0] reg1_r;
    logic [7:0] reg2_r;
    logic [7:0] reg3_r;
    logic [7:0] reg4_r;
    logic       wr_strobe_r;

    // Input synchronisers plus one history flop for edge detection.
    // ncs resets high so an idle bus is not mistaken for a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            copi_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_sync_r  <= {SYNC_STAGES{1'b1}};
            sclk_hist_r <= 1'b0;
            ncs_hist_r  <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], copi};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
            sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
            ncs_hist_r  <= ncs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign copi_s      = copi_sync_r[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_hist_r;
    assign ncs_rise_s  = ncs_s & ~ncs_hist_r;
    assign ncs_fall_s  = ~ncs_s & ncs_hist_r;

    // Frame state, shift register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= 16'h0000;
            bit_cnt_r <= 5'd0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
        end
    end

    // Next-state and commit decision. An ncs rise takes priority over an sclk
    // rise in the same cycle, so a trailing clock edge cannot add a bit. The
    // counter saturates one past a full frame so long frames stay rejected.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        wr_en_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_next_s   = SHIFT;
                    shift_next_s   = 16'h0000;
                    bit_cnt_next_s = 5'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise_s) begin
                    state_next_s = IDLE;
                    if ((bit_cnt_r == FRAME_BITS) && shift_r[15] &&
                        (shift_r[14:8] <= MAX_ADDR_C)) begin
                        wr_en_s = 1'b1;
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end else if (sclk_rise_s && !ncs_s) begin
                    shift_next_s = {shift_r[14:0], copi_s};
                    if (bit_cnt_r != CNT_SAT) begin
                        bit_cnt_next_s = bit_cnt_r + 5'd1;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r;
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Configuration registers and the registered write strobe. An in-range
    // address with no backing register still strobes but stores nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg0_r      <= 8'h00;
            reg1_r      <= 8'h00;
            reg2_r      <= 8'h00;
            reg3_r      <= 8'h00;
            reg4_r      <= 8'h00;
            wr_strobe_r <= 1'b0;
        end else begin
            wr_strobe_r <= wr_en_s;
            if (wr_en_s) begin
                case (shift_r[14:8])
                    7'd0:    reg0_r <= shift_r[7:0];
                    7'd1:    reg1_r <= shift_r[7:0];
                    7'd2:    reg2_r <= shift_r[7:0];
                    7'd3:    reg3_r <= shift_r[7:0];
                    7'd4:    reg4_r <= shift_r[7:0];
                    default: begin
                    end
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = reg0_r;
    assign en_reg_out_15_8 = reg1_r;
    assign en_reg_pwm_7_0  = reg2_r;
    assign en_reg_pwm_15_8 = reg3_r;
    assign pwm_duty_cycle  = reg4_r;
    assign wr_strobe       = wr_strobe_r;

endmodule
